// File: rtl/led_frame_engine.sv
// Frame-side datapath for the LED matrix panel: serializes the built-in pattern,
// steps the one-hot row select on each completed row and captures rows into a readable frame buffer.
module led_frame_engine #(
  parameter int row_w            = 32,
  parameter int col_w            = 16,
  parameter int number_of_frames = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      row_ready_i,
  input  logic [row_w-1:0]                          row_i,
  input  logic [((col_w > 1) ? $clog2(col_w) : 1)-1:0] rd_addr_i,
  output logic                                      serial_row_o,
  output logic [col_w-1:0]                          col_select,
  output logic [row_w-1:0]                          rd_data_o,
  output logic                                      frame_done_o
);

  localparam int BIT_W = (row_w > 1) ? $clog2(row_w) : 1;
  localparam int IDX_W = (col_w > 1) ? $clog2(col_w) : 1;
  localparam int FRM_W = (number_of_frames > 1) ? $clog2(number_of_frames) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(row_w - 1);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(col_w - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(number_of_frames - 1);

  logic [BIT_W-1:0] r_bit_idx;
  logic [IDX_W-1:0] r_row_idx;
  logic [FRM_W-1:0] r_frame_idx;
  logic [IDX_W-1:0] r_wr_row;
  logic [col_w-1:0] r_col_select;
  logic             r_frame_done;
  logic [row_w-1:0] r_buf [col_w];

  logic w_bit_last;
  logic w_row_last;
  logic w_wr_last;
  logic w_bit2;

  assign w_bit_last = (r_bit_idx == BIT_LAST);
  assign w_row_last = (r_row_idx == ROW_LAST);
  assign w_wr_last  = (r_wr_row == ROW_LAST);

  // Pattern toggles every 4 pixels; narrow rows never reach bit 2.
  generate
    if (BIT_W >= 3) begin : g_bit2
      assign w_bit2 = r_bit_idx[2];
    end else begin : g_no_bit2
      assign w_bit2 = 1'b0;
    end
  endgenerate

  assign serial_row_o = w_bit2 ^ r_row_idx[0] ^ r_frame_idx[0];
  assign col_select   = r_col_select;
  assign rd_data_o    = r_buf[rd_addr_i];
  assign frame_done_o = r_frame_done;

  // Pattern source free-runs and never looks at row_ready_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx   <= '0;
      r_row_idx   <= '0;
      r_frame_idx <= '0;
    end else if (w_bit_last) begin
      r_bit_idx <= '0;
      if (w_row_last) begin
        r_row_idx   <= '0;
        r_frame_idx <= (r_frame_idx == FRM_LAST) ? '0 : r_frame_idx + 1'b1;
      end else begin
        r_row_idx <= r_row_idx + 1'b1;
      end
    end else begin
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_select <= col_w'(1);
    end else if (row_ready_i) begin
      r_col_select <= {r_col_select[col_w-2:0], r_col_select[col_w-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_row     <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < col_w; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_frame_done <= row_ready_i & w_wr_last;
      if (row_ready_i) begin
        r_buf[r_wr_row] <= row_i;
        r_wr_row        <= w_wr_last ? '0 : r_wr_row + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_engine.sv
// Self-checking bench for led_frame_engine: directed scenarios plus a randomized run
// compared against an array/integer reference model of the frame engine.
module tb_led_frame_engine;

  localparam int ROW_W = 32;
  localparam int COL_W = 16;
  localparam int NF    = 1;

  logic              clk;
  logic              rst;
  logic              row_ready_i;
  logic [ROW_W-1:0]  row_i;
  logic [3:0]        rd_addr_i;
  logic              serial_row_o;
  logic [COL_W-1:0]  col_select;
  logic [ROW_W-1:0]  rd_data_o;
  logic              frame_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [ROW_W-1:0] m_buf [COL_W];
  int m_wr, m_col, m_k;
  logic m_done;

  led_frame_engine #(.row_w(ROW_W), .col_w(COL_W), .number_of_frames(NF)) dut (
    .clk(clk), .rst(rst), .row_ready_i(row_ready_i), .row_i(row_i),
    .rd_addr_i(rd_addr_i), .serial_row_o(serial_row_o), .col_select(col_select),
    .rd_data_o(rd_data_o), .frame_done_o(frame_done_o)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Stream bit k after reset: pixel b of row r of frame f is b[2]^r[0]^f[0].
  function automatic logic exp_ser(int k);
    int b, r, f;
    b = k % ROW_W;
    r = (k / ROW_W) % COL_W;
    f = (k / (ROW_W * COL_W)) % NF;
    return 1'(((b >> 2) & 1) ^ (r & 1) ^ (f & 1));
  endfunction

  // Advance model by the upcoming rising edge, then move to the next falling edge.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < COL_W; i++) m_buf[i] = '0;
      m_wr = 0; m_col = 0; m_k = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (row_ready_i) begin
        m_buf[m_wr] = row_i;
        m_done = (m_wr == COL_W - 1);
        m_wr   = (m_wr + 1) % COL_W;
        m_col  = (m_col + 1) % COL_W;
      end
      m_k++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    row_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (col_select !== 16'h0001) begin
      n_fail++; $display("FAIL reset_col_select got=%h exp=%h", col_select, 16'h0001);
    end
    n_checks++;
    if (serial_row_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_serial got=%b exp=0", serial_row_o);
    end
    n_checks++;
    if (frame_done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_o);
    end
    for (int a = 0; a < COL_W; a++) begin
      rd_addr_i = 4'(a);
      #1;
      n_checks++;
      if (rd_data_o !== 32'h0) begin
        n_fail++; $display("FAIL reset_rd_data addr=%0d got=%h exp=00000000", a, rd_data_o);
      end
    end
  endtask

  task automatic test_serial();
    int errs;
    do_reset();
    errs = 0;
    for (int k = 0; k < 600; k++) begin
      n_checks++;
      if (serial_row_o !== exp_ser(k)) begin
        n_fail++; errs++;
        if (errs < 8) $display("FAIL serial_stream cycle=%0d got=%b exp=%b", k, serial_row_o, exp_ser(k));
      end
      tick();
    end
  endtask

  task automatic test_row_select();
    logic [COL_W-1:0] exp_cs;
    do_reset();
    for (int p = 0; p < COL_W; p++) begin
      row_ready_i = 1'b1;
      row_i = $urandom;
      tick();
      row_ready_i = 1'b0;
      exp_cs = 16'h0001 << ((p + 1) % COL_W);
      n_checks++;
      if (col_select !== exp_cs) begin
        n_fail++; $display("FAIL row_select pulse=%0d got=%h exp=%h", p, col_select, exp_cs);
      end
      for (int g = 0; g < 31; g++) tick();
      n_checks++;
      if (col_select !== exp_cs) begin
        n_fail++; $display("FAIL row_select_hold pulse=%0d got=%h exp=%h", p, col_select, exp_cs);
      end
    end
  endtask

  task automatic test_frame_save();
    int dones;
    logic [ROW_W-1:0] exp_w;
    do_reset();
    dones = 0;
    for (int p = 0; p < COL_W; p++) begin
      row_ready_i = 1'b1;
      row_i = (p % 2 == 0) ? 32'hF0F0F0F0 : 32'h0F0F0F0F;
      tick();
      row_ready_i = 1'b0;
      if (frame_done_o === 1'b1) dones++;
      n_checks++;
      if (frame_done_o !== (p == COL_W - 1)) begin
        n_fail++; $display("FAIL frame_done pulse=%0d got=%b exp=%b", p, frame_done_o, (p == COL_W - 1));
      end
      for (int g = 0; g < int'($urandom_range(0, 4)); g++) begin
        tick();
        if (frame_done_o === 1'b1) dones++;
      end
    end
    for (int g = 0; g < 3; g++) begin
      tick();
      if (frame_done_o === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL frame_done_count got=%0d exp=1", dones);
    end
    for (int a = 0; a < COL_W; a++) begin
      rd_addr_i = 4'(a);
      #1;
      exp_w = (a % 2 == 0) ? 32'hF0F0F0F0 : 32'h0F0F0F0F;
      n_checks++;
      if (rd_data_o !== exp_w) begin
        n_fail++; $display("FAIL frame_readback addr=%0d got=%h exp=%h", a, rd_data_o, exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      row_ready_i = 1'b1;
      row_i = $urandom;
      tick();
      row_ready_i = 1'b0;
      for (int g = 0; g < 19; g++) tick();
    end
    rst = 1'b1;
    row_ready_i = 1'b1;
    row_i = 32'hDEADBEEF;
    tick();
    rst = 1'b0;
    row_ready_i = 1'b0;
    n_checks++;
    if (col_select !== 16'h0001) begin
      n_fail++; $display("FAIL midreset_col_select got=%h exp=0001", col_select);
    end
    n_checks++;
    if (frame_done_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_frame_done got=%b exp=0", frame_done_o);
    end
    for (int a = 0; a < COL_W; a++) begin
      rd_addr_i = 4'(a);
      #1;
      n_checks++;
      if (rd_data_o !== 32'h0) begin
        n_fail++; $display("FAIL midreset_buffer addr=%0d got=%h exp=00000000", a, rd_data_o);
      end
    end
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (serial_row_o !== exp_ser(k)) begin
        n_fail++; $display("FAIL midreset_serial cycle=%0d got=%b exp=%b", k, serial_row_o, exp_ser(k));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      row_ready_i = 1'b1;
      row_i = 32'(v);
      tick();
    end
    row_ready_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_addr_i = 4'(a);
      #1;
      n_checks++;
      if (rd_data_o !== 32'((a < 3) ? a + 1 : 0)) begin
        n_fail++; $display("FAIL b2b_buffer addr=%0d got=%h exp=%h", a, rd_data_o, 32'((a < 3) ? a + 1 : 0));
      end
    end
    n_checks++;
    if (col_select !== 16'h0008) begin
      n_fail++; $display("FAIL b2b_col_select got=%h exp=0008", col_select);
    end
  endtask

  task automatic test_random();
    int errs;
    logic [COL_W-1:0] exp_cs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 1200; c++) begin
      row_ready_i = ($urandom_range(0, 2) == 0);
      row_i       = $urandom;
      rd_addr_i   = 4'($urandom_range(0, COL_W - 1));
      rst         = ($urandom_range(0, 150) == 0);
      #1;
      exp_cs = 16'h0001 << m_col;
      n_checks++;
      if (rd_data_o !== m_buf[rd_addr_i] || serial_row_o !== exp_ser(m_k) ||
          col_select !== exp_cs || frame_done_o !== m_done) begin
        n_fail++; errs++;
        if (errs < 8)
          $display("FAIL random cycle=%0d rd=%h/%h ser=%b/%b cs=%h/%h done=%b/%b (got/exp)",
                   c, rd_data_o, m_buf[rd_addr_i], serial_row_o, exp_ser(m_k),
                   col_select, exp_cs, frame_done_o, m_done);
      end
      tick();
    end
    rst = 1'b0;
    row_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    row_ready_i = 1'b0;
    row_i = '0;
    rd_addr_i = '0;
    for (int i = 0; i < COL_W; i++) m_buf[i] = '0;
    m_wr = 0; m_col = 0; m_k = 0; m_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_serial();
    test_row_select();
    test_frame_save();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
